muladd_frame_accumulator: RTL and testbench

- Downstream consumer of the pipelined multiply-add stage. It takes the 64-bit product-plus-addend results, one per clock, qualified by a valid flag.
- It sums FRAME_LEN consecutive results into one frame total.
- Completed totals go into a 2-entry output buffer drained by a valid/ready handshake. The upstream stage cannot stall, so backpressure is absorbed here.

---
 rtl/muladd_frame_accumulator_if.sv | 43 ++++
 rtl/muladd_frame_accumulator.sv | 233 +++++++++++++++++++++++
 tb/tb_muladd_frame_accumulator.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muladd_frame_accumulator_if.sv
// Stream bundle between the multiply-add stage, the frame accumulator and the
// consumer of frame totals. With MULACC_SATURATE_EN defined the bundle also
// carries out_sat, a per-total flag that saturation happened in that frame.
//
// Handshakes:
//   input side  - p_valid qualifies p_in for one cycle; there is no ready,
//                 because the upstream stage never stalls.
//   output side - a total transfers on every rising clk edge where
//                 out_valid && out_ready. While out_valid is high and
//                 out_ready is low, out_data (and out_sat) hold steady.
//                 out_valid never drops until its entry has transferred.
interface muladd_frame_accumulator_if #(
    parameter int IN_W  = 64,
    parameter int ACC_W = 68
);
    logic [IN_W-1:0]  p_in;
    logic             p_valid;
    logic             clear;
    logic [ACC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef MULACC_SATURATE_EN
    logic             out_sat;

    modport master (
        output p_in, p_valid, clear, out_ready,
        input  out_data, out_valid, out_sat
    );
    modport slave (
        input  p_in, p_valid, clear, out_ready,
        output out_data, out_valid, out_sat
    );
`else
    modport master (
        output p_in, p_valid, clear, out_ready,
        input  out_data, out_valid
    );
    modport slave (
        input  p_in, p_valid, clear, out_ready,
        output out_data, out_valid
    );
`endif
endinterface

// File: rtl/muladd_frame_accumulator.sv
// Frame accumulator behind the pipelined multiply-add stage.
// Sums FRAME_LEN valid results into one ACC_W-bit total and queues totals in
// a 2-entry in-order buffer drained by valid/ready. The upstream stage cannot
// stall, so a total that finds the buffer full (and no pop that cycle) is
// dropped and the sticky overflow flag is set.
// clear aborts the current frame and clears overflow but keeps buffered totals.
// Optional feature, macro MULACC_SATURATE_EN: accumulation saturates at
// 2^ACC_W-1 instead of wrapping, and each buffered total carries out_sat.
// state_dbg exposes the frame FSM: 0 = ACC_IDLE, 1 = ACC_RUN.
module muladd_frame_accumulator #(
    parameter int IN_W      = 64,
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 68,
    localparam int CNT_W    = $clog2(FRAME_LEN)
) (
    input  logic                      clk,
    input  logic                      reset,
    muladd_frame_accumulator_if.slave bus,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic                      overflow,
    output logic                      state_dbg
);

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

    acc_state_t       state;
    acc_state_t       state_nxt;

    // FSM decode outputs
    logic             take_sample;   // a p_valid sample is consumed this cycle
    logic             start_frame;   // consumed sample is the first of a frame
    logic             frame_done;    // consumed sample completes the frame

    logic             cnt_last;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum_val;

    // Output buffer: head entry drives the outputs directly, tail is entry two
    logic [ACC_W-1:0] head_data;
    logic             head_valid;
    logic [ACC_W-1:0] tail_data;
    logic             tail_valid;

    logic             pop;
    logic             push;
    logic             drop;
    logic             head_load_new;
    logic             head_load_tail;
    logic             tail_load;
    logic             head_valid_nxt;
    logic             tail_valid_nxt;

`ifdef MULACC_SATURATE_EN
    logic [ACC_W:0]   sum_wide;
    logic             sum_carry;
    logic             frame_sat;
    logic             sat_val;
    logic             head_sat;
    logic             tail_sat;
`endif

    assign cnt_last = (frame_cnt == CNT_W'(FRAME_LEN - 1));

    // Frame FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next state: clear always wins over a sample in the same cycle
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = ACC_IDLE;
        end else if (bus.p_valid) begin
            case (state)
                ACC_IDLE: state_nxt = ACC_RUN;
                ACC_RUN:  state_nxt = cnt_last ? ACC_IDLE : ACC_RUN;
                default:  state_nxt = ACC_IDLE;
            endcase
        end
    end

    // Frame FSM outputs: qualify the incoming sample for the datapath
    always_comb begin
        take_sample = bus.p_valid && !bus.clear;
        start_frame = 1'b0;
        frame_done  = 1'b0;
        if (take_sample) begin
            start_frame = (state == ACC_IDLE);
            frame_done  = (state == ACC_RUN) && cnt_last;
        end
    end

    assign state_dbg = (state == ACC_RUN);

    // The first sample of a frame replaces the accumulator instead of adding
    assign p_ext    = ACC_W'(bus.p_in);
    assign acc_base = start_frame ? '0 : acc;

`ifdef MULACC_SATURATE_EN
    assign sum_wide  = {1'b0, acc_base} + {1'b0, p_ext};
    assign sum_carry = sum_wide[ACC_W];
    assign sum_val   = sum_carry ? '1 : sum_wide[ACC_W-1:0];
    assign sat_val   = (start_frame ? 1'b0 : frame_sat) | sum_carry;
`else
    assign sum_val   = acc_base + p_ext;
`endif

    // Accumulator and sample counter; both restart on completion or clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            frame_cnt <= '0;
        end else if (bus.clear || frame_done) begin
            acc       <= '0;
            frame_cnt <= '0;
        end else if (take_sample) begin
            acc       <= sum_val;
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

`ifdef MULACC_SATURATE_EN
    // Running per-frame saturation flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_sat <= 1'b0;
        end else if (bus.clear || frame_done) begin
            frame_sat <= 1'b0;
        end else if (take_sample) begin
            frame_sat <= sat_val;
        end
    end
`endif

    assign pop  = head_valid && bus.out_ready;
    assign push = frame_done;
    // A full buffer still accepts a push when the head pops in the same cycle
    assign drop = push && head_valid && tail_valid && !pop;

    // Buffer control: decide which entry loads what this cycle
    always_comb begin
        head_load_new  = 1'b0;
        head_load_tail = 1'b0;
        tail_load      = 1'b0;
        head_valid_nxt = head_valid;
        tail_valid_nxt = tail_valid;
        if (pop) begin
            if (tail_valid) begin
                head_load_tail = 1'b1;
                tail_load      = push;
                tail_valid_nxt = push;
            end else begin
                head_load_new  = push;
                head_valid_nxt = push;
            end
        end else if (push) begin
            if (!head_valid) begin
                head_load_new  = 1'b1;
                head_valid_nxt = 1'b1;
            end else if (!tail_valid) begin
                tail_load      = 1'b1;
                tail_valid_nxt = 1'b1;
            end
        end
    end

    // Buffer registers; head_data is left as-is when the buffer empties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_data  <= '0;
            head_valid <= 1'b0;
            tail_data  <= '0;
            tail_valid <= 1'b0;
        end else begin
            head_valid <= head_valid_nxt;
            tail_valid <= tail_valid_nxt;
            if (head_load_tail) begin
                head_data <= tail_data;
            end else if (head_load_new) begin
                head_data <= sum_val;
            end
            if (tail_load) begin
                tail_data <= sum_val;
            end
        end
    end

`ifdef MULACC_SATURATE_EN
    // Saturation flags travel with their totals through the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_sat <= 1'b0;
            tail_sat <= 1'b0;
        end else begin
            if (head_load_tail) begin
                head_sat <= tail_sat;
            end else if (head_load_new) begin
                head_sat <= sat_val;
            end
            if (tail_load) begin
                tail_sat <= sat_val;
            end
        end
    end

    assign bus.out_sat = head_sat;
`endif

    // Sticky overflow: set by a dropped total, cleared only by clear or reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (bus.clear) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign bus.out_data  = head_data;
    assign bus.out_valid = head_valid;

endmodule

// File: tb/tb_muladd_frame_accumulator.sv
// Bench for muladd_frame_accumulator with FRAME_LEN=4, IN_W=ACC_W=64.
// Reference model: the samples of the open frame are kept in a queue and
// summed with wide plain arithmetic when the frame completes; the output
// buffer is a queue of at most two expected totals.
module tb_muladd_frame_accumulator;

    localparam int IN_W      = 64;
    localparam int ACC_W     = 64;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] frame_cnt;
    logic             overflow;
    logic             state_dbg;

    muladd_frame_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

    muladd_frame_accumulator #(
        .IN_W      (IN_W),
        .FRAME_LEN (FRAME_LEN),
        .ACC_W     (ACC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .frame_cnt (frame_cnt),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [IN_W-1:0]  cur_samples[$];
    logic [ACC_W-1:0] exp_q[$];
    bit               exp_sat_q[$];
    bit               exp_overflow;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        cur_samples.delete();
        exp_q.delete();
        exp_sat_q.delete();
        exp_overflow = 0;
    endfunction

    function automatic void frame_total(output logic [ACC_W-1:0] val, output bit sat);
        logic [127:0] t;
        logic [127:0] maxv;
        t    = '0;
        maxv = (128'd1 << ACC_W) - 128'd1;
        foreach (cur_samples[i]) t += 128'(cur_samples[i]);
`ifdef MULACC_SATURATE_EN
        sat = (t > maxv);
        val = sat ? maxv[ACC_W-1:0] : t[ACC_W-1:0];
`else
        sat = 0;
        val = t[ACC_W-1:0];
`endif
    endfunction

    // Advance the model by one clock edge with the given inputs
    function automatic void model_step(input bit v, input logic [IN_W-1:0] d, input bit c, input bit r);
        bit               pop;
        bit               push;
        logic [ACC_W-1:0] tot;
        bit               sat;
        pop  = (exp_q.size() != 0) && r;
        push = 0;
        tot  = '0;
        sat  = 0;
        if (c) begin
            cur_samples.delete();
            exp_overflow = 0;
        end else if (v) begin
            cur_samples.push_back(d);
            if (cur_samples.size() == FRAME_LEN) begin
                frame_total(tot, sat);
                push = 1;
                cur_samples.delete();
            end
        end
        if (pop) begin
            void'(exp_q.pop_front());
            void'(exp_sat_q.pop_front());
        end
        if (push) begin
            if (exp_q.size() < 2) begin
                exp_q.push_back(tot);
                exp_sat_q.push_back(sat);
            end else begin
                exp_overflow = 1;
            end
        end
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_eq("out_data", bus.out_data, exp_q[0]);
`ifdef MULACC_SATURATE_EN
            check_eq("out_sat", bus.out_sat, exp_sat_q[0]);
`endif
        end
        check_eq("frame_cnt", frame_cnt, cur_samples.size());
        check_eq("overflow", overflow, exp_overflow);
        check_eq("state_run", state_dbg, cur_samples.size() != 0);
    endtask

    // Driver: called at a falling edge; applies inputs for the next rising
    // edge, then checks the outputs at the following falling edge
    task automatic cycle(input bit v, input logic [IN_W-1:0] d, input bit c, input bit r);
        bus.p_valid   = v;
        bus.p_in      = d;
        bus.clear     = c;
        bus.out_ready = r;
        model_step(v, d, c, r);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, r);
    endtask

    logic [IN_W-1:0] vals[8];
    logic [IN_W-1:0] all_ones;

    initial begin
        all_ones      = '1;
        reset         = 1'b1;
        bus.p_in      = '0;
        bus.p_valid   = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset for three cycles, then release while samples are streaming
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_overflow", overflow, 0);
        bus.p_valid = 1'b1;
        bus.p_in    = 64'd55;
        @(negedge clk);
        reset = 1'b0;
        cycle(1, 64'd1, 0, 1);
        check_eq("rst_first_sample", frame_cnt, 1);
        cycle(1, 64'd2, 0, 1);
        cycle(1, 64'd3, 0, 1);
        cycle(1, 64'd4, 0, 1);
        check_eq("rst_frame_sum", bus.out_data, 10);
        idle(2, 1);

        // Single frame, valid exactly one cycle after the last sample
        cycle(1, 64'd1, 0, 1);
        cycle(1, 64'd2, 0, 1);
        cycle(1, 64'd3, 0, 1);
        check_eq("t2_not_yet", bus.out_valid, 0);
        cycle(1, 64'd4, 0, 1);
        check_eq("t2_sum", bus.out_data, 10);
        check_eq("t2_valid", bus.out_valid, 1);
        cycle(0, '0, 0, 1);
        check_eq("t2_one_beat", bus.out_valid, 0);

        // Back-to-back frames, then the same frames with random gaps
        vals = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd10, 64'd20, 64'd30, 64'd40};
        for (int i = 0; i < 8; i++) cycle(1, vals[i], 0, 1);
        check_eq("t3_second_sum", bus.out_data, 100);
        idle(2, 1);
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            idle(gap, 1);
            cycle(1, vals[i], 0, 1);
        end
        idle(2, 1);

        // Backpressure: two frames buffered, third dropped, then drain, clear
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 4; i++) cycle(1, 64'd1, 0, 0);
        check_eq("t4_head", bus.out_data, 4);
        check_eq("t4_overflow", overflow, 1);
        idle(2, 0);
        check_eq("t4_hold", bus.out_data, 4);
        cycle(0, '0, 0, 1);
        check_eq("t4_second", bus.out_data, 4);
        cycle(0, '0, 0, 1);
        check_eq("t4_drained", bus.out_valid, 0);
        check_eq("t4_sticky", overflow, 1);
        cycle(0, '0, 1, 1);
        check_eq("t4_clear_ovf", overflow, 0);

        // Clear with a simultaneous sample aborts the partial frame
        cycle(1, 64'd7, 0, 1);
        cycle(1, 64'd7, 0, 1);
        cycle(1, 64'd99, 1, 1);
        check_eq("t5_after_clear", frame_cnt, 0);
        for (int i = 0; i < 4; i++) cycle(1, 64'd5, 0, 1);
        check_eq("t5_sum", bus.out_data, 20);
        check_eq("t5_cnt", frame_cnt, 0);
        idle(1, 1);

        // Wrap or saturate on all-ones followed by ones
        cycle(1, all_ones, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 64'd1, 0, 0);
`ifdef MULACC_SATURATE_EN
        check_eq("t6_sat_val", bus.out_data, all_ones);
        check_eq("t6_sat_flag", bus.out_sat, 1);
`else
        check_eq("t6_wrap_val", bus.out_data, 2);
`endif
        cycle(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 64'd1, 0, 1);
        check_eq("t6_next_frame", bus.out_data, 4);
`ifdef MULACC_SATURATE_EN
        check_eq("t6_next_sat", bus.out_sat, 0);
`endif
        idle(1, 1);

        // Asynchronous reset in the middle of a frame with a buffered total
        for (int i = 0; i < 6; i++) cycle(1, 64'(i + 3), 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("arst_out_valid", bus.out_valid, 0);
        check_eq("arst_out_data", bus.out_data, 0);
        check_eq("arst_frame_cnt", frame_cnt, 0);
        check_eq("arst_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(1, 1);

        // Randomized traffic: mostly-ready phase, then heavy backpressure
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 400; n++) begin
                bit              v;
                bit              c;
                bit              r;
                logic [IN_W-1:0] d;
                v = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 40) == 0);
                r = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
                case ($urandom_range(0, 3))
                    0:       d = all_ones;
                    1:       d = IN_W'($urandom_range(0, 255));
                    default: d = {$urandom, $urandom};
                endcase
                cycle(v, d, c, r);
            end
        end
        idle(4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
